id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register of the five-stage RV32I core, with integrated load-use hazard detection. It captures decoded operands, immediate, destination and control bits from Decode and presents them, registered, to Execute. There they feed the ALU-source operand mux (`ex_rs2_data` vs `ex_imm`, selected by `ex_alu_src`). The block inserts bubbles on load-use hazards, squashes on taken branches and holds on back-pressure from Execute/Memory.

---
 rtl/core_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 27 ++
 rtl/id_ex_pipe_reg.sv | 114 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths and the EX-stage control bundle.
package core_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic    alu_src;
      alu_op_e alu_op;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
      logic    branch;
      logic    jump;
   } ex_ctrl_t;

   // All-zero control word: a bubble must never write registers or memory.
   localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and
// the instruction currently in ID.
module load_use_detect #(
   parameter int REG_AW = core_pkg::REG_AW
) (
   input  logic              id_valid,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              hz
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

   // x0 is never written, so a load targeting it creates no dependency.
   assign hz = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
               && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: bubbles on load-use, squashes on flush, freezes on hold,
// and counts inserted load-use bubbles (saturating).
module id_ex_pipe_reg
   import core_pkg::*;
#(
   parameter int XLEN   = core_pkg::XLEN,
   parameter int REG_AW = core_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  ex_ctrl_t          id_ctrl,
   input  logic              ex_flush,
   input  logic              ex_hold,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output ex_ctrl_t          ex_ctrl,
   output logic              id_stall,
   output logic [31:0]       bubble_cnt
);

   logic hz;
   logic load_bubble;
   logic capture;
   logic count_bubble;

   load_use_detect #(.REG_AW(REG_AW)) u_lud (
      .id_valid    (id_valid),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl.mem_read),
      .ex_rd       (ex_rd),
      .hz          (hz)
   );

   assign id_stall = (hz || ex_hold) && !ex_flush;

   // Flush beats hold beats hazard; an invalid ID slot also loads a clean bubble.
   always_comb begin
      load_bubble  = 1'b0;
      capture      = 1'b0;
      count_bubble = 1'b0;
      if (ex_flush) begin
         load_bubble = 1'b1;
      end else if (!ex_hold) begin
         if (hz) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
         end else if (id_valid) begin
            capture = 1'b1;
         end else begin
            load_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= EX_CTRL_NOP;
         bubble_cnt  <= '0;
      end else begin
         if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= EX_CTRL_NOP;
         end else if (capture) begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
         end
         if (count_bubble && (bubble_cnt != 32'hFFFF_FFFF))
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed test-plan cases then random traffic.
module tb_id_ex_pipe_reg;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic              id_uses_rs1, id_uses_rs2;
   ex_ctrl_t          id_ctrl;
   logic              ex_flush, ex_hold;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   ex_ctrl_t          ex_ctrl;
   logic              id_stall;
   logic [31:0]       bubble_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl),
      .ex_flush(ex_flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   typedef struct {
      logic              rst, valid, uses1, uses2, flush, hold;
      logic [XLEN-1:0]   pc, d1, d2, imm;
      logic [REG_AW-1:0] rs1, rs2, rd;
      ex_ctrl_t          ctrl;
   } stim_t;

   // What the EX stage is expected to hold after an edge.
   typedef struct {
      logic              valid;
      logic [XLEN-1:0]   pc, d1, d2, imm;
      logic [REG_AW-1:0] rs1, rs2, rd;
      ex_ctrl_t          ctrl;
      logic [31:0]       cnt;
   } ex_t;

   ex_t  model;
   ex_t  exp_q[$];
   logic stall_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the instruction in EX is whatever the pipeline rules say it should be.
   task automatic drive(input stim_t s);
      logic  dep, hazard;
      ex_t   nxt;
      ex_t   empty;
      @(negedge clk);
      rst = s.rst; id_valid = s.valid; id_uses_rs1 = s.uses1; id_uses_rs2 = s.uses2;
      ex_flush = s.flush; ex_hold = s.hold; id_pc = s.pc; id_rs1_data = s.d1;
      id_rs2_data = s.d2; id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_rd = s.rd; id_ctrl = s.ctrl;
      dep    = (s.uses1 && s.rs1 == model.rd) || (s.uses2 && s.rs2 == model.rd);
      hazard = s.valid && model.valid && model.ctrl.mem_read && model.rd != 0 && dep;
      stall_q.push_back((hazard || s.hold) && !s.flush);
      empty = '{valid: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0,
                rd: '0, ctrl: '0, cnt: model.cnt};
      nxt = model;
      if (s.rst) begin
         nxt = empty;
         nxt.cnt = 0;
      end else if (s.flush) begin
         nxt = empty;
      end else if (s.hold) begin
         nxt = model;
      end else if (hazard) begin
         nxt = empty;
         if (model.cnt != 32'hFFFF_FFFF) nxt.cnt = model.cnt + 1;
      end else if (s.valid) begin
         nxt = '{valid: 1'b1, pc: s.pc, d1: s.d1, d2: s.d2, imm: s.imm, rs1: s.rs1,
                 rs2: s.rs2, rd: s.rd, ctrl: s.ctrl, cnt: model.cnt};
      end else begin
         nxt = empty;
      end
      model = nxt;
      exp_q.push_back(nxt);
   endtask

   // Combinational stall is sampled mid-cycle, well after inputs settle.
   initial forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) chk("id_stall", 32'(id_stall), 32'(stall_q.pop_front()));
   end

   initial forever begin
      ex_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ex_valid", 32'(ex_valid), 32'(e.valid));
         chk("ex_pc", ex_pc, e.pc);
         chk("ex_rs1_data", ex_rs1_data, e.d1);
         chk("ex_rs2_data", ex_rs2_data, e.d2);
         chk("ex_imm", ex_imm, e.imm);
         chk("ex_rs1", 32'(ex_rs1), 32'(e.rs1));
         chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
         chk("ex_rd", 32'(ex_rd), 32'(e.rd));
         chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
         chk("bubble_cnt", bubble_cnt, e.cnt);
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, valid: 1'b0, uses1: 1'b0, uses2: 1'b0, flush: 1'b0, hold: 1'b0,
            pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, ctrl: '0};
      return s;
   endfunction

   function automatic stim_t instr(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u1, input logic u2, input logic [31:0] imm,
                                   input ex_ctrl_t c);
      stim_t s;
      s = idle();
      s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
      s.uses1 = u1; s.uses2 = u2; s.imm = imm; s.ctrl = c;
      s.d1 = $urandom; s.d2 = $urandom;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.rst   = ($urandom_range(0, 99) < 3);
      s.valid = ($urandom_range(0, 99) < 80);
      s.uses1 = $urandom_range(0, 1);
      s.uses2 = $urandom_range(0, 1);
      s.flush = ($urandom_range(0, 99) < 10);
      s.hold  = ($urandom_range(0, 99) < 20);
      s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.ctrl = ex_ctrl_t'(11'($urandom_range(0, 2047)));
      return s;
   endfunction

   initial begin
      ex_ctrl_t c_addi, c_lw, c_add;
      stim_t s;
      int wait_cycles;
      c_addi = '0; c_addi.alu_src = 1'b1; c_addi.reg_write = 1'b1; c_addi.alu_op = ALU_ADD;
      c_lw = c_addi; c_lw.mem_read = 1'b1; c_lw.mem_to_reg = 1'b1;
      c_add = '0; c_add.reg_write = 1'b1; c_add.alu_op = ALU_ADD;

      s = idle();
      rst = 1'b1; id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_flush = 1'b0; ex_hold = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
      id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_ctrl = '0;
      model = '{valid: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0,
                rd: '0, ctrl: '0, cnt: '0};
      @(posedge clk);
      s.rst = 1'b1;
      drive(s);

      // addi x5,x0,7
      drive(instr(32'h100, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 32'd7, c_addi));
      // lw x6 followed by add x7,x6,x1: one bubble, then the add enters
      drive(instr(32'h104, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0, c_lw));
      s = instr(32'h108, 5'd7, 5'd6, 5'd1, 1'b1, 1'b1, 32'd0, c_add);
      drive(s);
      drive(s);
      // lw x0 then reader of x0: no hazard
      drive(instr(32'h10c, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 32'd4, c_lw));
      drive(instr(32'h110, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0, c_add));
      // flush wins over hazard and hold
      drive(instr(32'h114, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0, c_lw));
      s = instr(32'h118, 5'd9, 5'd6, 5'd0, 1'b1, 1'b0, 32'd0, c_add);
      s.flush = 1'b1; s.hold = 1'b1;
      drive(s);
      // hold three cycles with changing ID contents
      drive(instr(32'h11c, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 32'h55, c_add));
      for (int i = 0; i < 3; i++) begin
         s = instr(32'h200 + 4 * i, 5'(i + 11), 5'd3, 5'd4, 1'b1, 1'b1, $urandom, c_addi);
         s.hold = 1'b1;
         drive(s);
      end
      // reset asserted during a hazard
      drive(instr(32'h120, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0, c_lw));
      s = instr(32'h124, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, 32'd0, c_add);
      s.rst = 1'b1;
      drive(s);
      drive(s);

      for (int i = 0; i < 600; i++) drive(rnd());
      drive(idle());

      wait_cycles = 0;
      while ((exp_q.size() > 0 || stall_q.size() > 0) && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #3;
      if (exp_q.size() > 0 || stall_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size() + stall_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
